// File: rtl/mood_level_integrator_pkg.sv
// Shared mood encoding and helpers for the mood level integrator and its consumers.
// The display/behaviour blocks rely on this same LOW/MID/HIGH encoding.
package mood_level_integrator_pkg;

    localparam int MOOD_W = 2;

    typedef enum logic [MOOD_W-1:0] {
        MOOD_LOW  = 2'd0,
        MOOD_MID  = 2'd1,
        MOOD_HIGH = 2'd2
    } mood_e;

    // Counter width that stays legal when the count range collapses to a single value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mood_level_integrator_if.sv
// Stimulus inputs and level/mood outputs of the mood level integrator.
interface mood_level_integrator_if #(
    parameter int WIDTH = 8
);
    import mood_level_integrator_pkg::*;

    logic              tick;
    logic              nourish;
    logic              stress;
    logic [WIDTH-1:0]  level;
    logic [MOOD_W-1:0] mood;
    logic              mood_changed;
    logic              decay_event;

    modport master (
        output tick, nourish, stress,
        input  level, mood, mood_changed, decay_event
    );

    modport slave (
        input  tick, nourish, stress,
        output level, mood, mood_changed, decay_event
    );

endinterface

// File: rtl/rising_edge_detect.sv
// Single-cycle pulse on each 0->1 transition of a clk-synchronous level.
module rising_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic in_q;

    // History clears on reset, so an input already high at release counts as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/mood_level_integrator.sv
// Saturating, leaky integrator of nourish/stress events with a hysteretic
// three-state mood classifier on the registered level.
module mood_level_integrator
    import mood_level_integrator_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MAX_LEVEL   = 255,
    parameter int INIT_LEVEL  = 128,
    parameter int INC_STEP    = 16,
    parameter int DEC_STEP    = 16,
    parameter int DECAY_STEP  = 1,
    parameter int DECAY_TICKS = 4,
    parameter int TH_MID_UP   = 96,
    parameter int TH_MID_DN   = 80,
    parameter int TH_HIGH_UP  = 192,
    parameter int TH_HIGH_DN  = 176
) (
    input logic                    clk,
    input logic                    rst,
    mood_level_integrator_if.slave bus
);

    localparam int CNT_W = cnt_width(DECAY_TICKS);
    localparam int SUM_W = WIDTH + 3;

    localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(DECAY_TICKS - 1);
    localparam logic signed [SUM_W-1:0] INC_S     = SUM_W'(INC_STEP);
    localparam logic signed [SUM_W-1:0] DEC_S     = SUM_W'(DEC_STEP);
    localparam logic signed [SUM_W-1:0] DECAY_S   = SUM_W'(DECAY_STEP);
    localparam logic signed [SUM_W-1:0] MAX_S     = SUM_W'(MAX_LEVEL);
    localparam logic [WIDTH-1:0]        MAX_L     = WIDTH'(MAX_LEVEL);
    localparam logic [WIDTH-1:0]        INIT_L    = WIDTH'(INIT_LEVEL);
    localparam logic [WIDTH-1:0]        MID_UP_L  = WIDTH'(TH_MID_UP);
    localparam logic [WIDTH-1:0]        MID_DN_L  = WIDTH'(TH_MID_DN);
    localparam logic [WIDTH-1:0]        HIGH_UP_L = WIDTH'(TH_HIGH_UP);
    localparam logic [WIDTH-1:0]        HIGH_DN_L = WIDTH'(TH_HIGH_DN);

    function automatic logic [WIDTH-1:0] sat_level(input logic signed [SUM_W-1:0] s);
        if (s[SUM_W-1]) begin
            return '0;
        end else if (s > MAX_S) begin
            return MAX_L;
        end else begin
            return s[WIDTH-1:0];
        end
    endfunction

    logic                    inc_e_p0;
    logic                    dec_e_p0;
    logic                    decay_fire_p0;
    logic [CNT_W-1:0]        decay_cnt;
    logic signed [SUM_W-1:0] sum_p0;
    logic [WIDTH-1:0]        level_p1;
    logic                    decay_event_p1;
    mood_e                   mood_q;
    logic                    mood_changed_q;

    rising_edge_detect u_nourish_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (bus.nourish),
        .pulse (inc_e_p0)
    );

    rising_edge_detect u_stress_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (bus.stress),
        .pulse (dec_e_p0)
    );

    // Stage p0: tick-gated decay counter, events combined into one signed sum.
    assign decay_fire_p0 = bus.tick && (decay_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decay_cnt <= '0;
        end else if (bus.tick) begin
            decay_cnt <= decay_fire_p0 ? '0 : decay_cnt + 1'b1;
        end
    end

    always_comb begin
        sum_p0 = $signed({3'b000, level_p1});
        if (inc_e_p0) begin
            sum_p0 = sum_p0 + INC_S;
        end
        if (dec_e_p0) begin
            sum_p0 = sum_p0 - DEC_S;
        end
        if (decay_fire_p0) begin
            sum_p0 = sum_p0 - DECAY_S;
        end
    end

    // Stage p1: clamped level and the decay marker become visible together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_p1       <= INIT_L;
            decay_event_p1 <= 1'b0;
        end else begin
            level_p1       <= sat_level(sum_p0);
            decay_event_p1 <= decay_fire_p0;
        end
    end

    // Mood follows the registered level one cycle later, one step per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mood_q         <= MOOD_LOW;
            mood_changed_q <= 1'b0;
        end else begin
            mood_changed_q <= 1'b0;
            unique case (mood_q)
                MOOD_LOW: begin
                    if (level_p1 >= MID_UP_L) begin
                        mood_q         <= MOOD_MID;
                        mood_changed_q <= 1'b1;
                    end
                end
                MOOD_MID: begin
                    if (level_p1 < MID_DN_L) begin
                        mood_q         <= MOOD_LOW;
                        mood_changed_q <= 1'b1;
                    end else if (level_p1 >= HIGH_UP_L) begin
                        mood_q         <= MOOD_HIGH;
                        mood_changed_q <= 1'b1;
                    end
                end
                MOOD_HIGH: begin
                    if (level_p1 < HIGH_DN_L) begin
                        mood_q         <= MOOD_MID;
                        mood_changed_q <= 1'b1;
                    end
                end
                default: begin
                    mood_q         <= MOOD_LOW;
                    mood_changed_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.level        = level_p1;
    assign bus.mood         = mood_q;
    assign bus.mood_changed = mood_changed_q;
    assign bus.decay_event  = decay_event_p1;

endmodule

// File: doc/mood_level_integrator.md
Name: mood_level_integrator

Overview:
- Consumes the single-cycle `tick` pulse produced by the periodic pulse counter.
- Integrates discrete stimulus events (nourish / stress) into a saturating level that leaks away over time.
- Classifies the level into a three-state mood with hysteresis.
- Sits between the time-base counter and the mood/display logic, which consume `mood` and `mood_changed`.

Parameters:
- WIDTH, 8, bit width of `level`.
- MAX_LEVEL, 255, saturation ceiling; must be <= 2^WIDTH-1.
- INIT_LEVEL, 128, `level` value on reset.
- INC_STEP, 16, amount added per `nourish` rising edge.
- DEC_STEP, 16, amount subtracted per `stress` rising edge.
- DECAY_STEP, 1, amount subtracted per decay event.
- DECAY_TICKS, 4, number of `tick` pulses per decay event; must be >= 1.
- TH_MID_UP, 96, LOW->MID threshold (level >= value).
- TH_MID_DN, 80, MID->LOW threshold (level < value); must be < TH_MID_UP.
- TH_HIGH_UP, 192, MID->HIGH threshold (level >= value).
- TH_HIGH_DN, 176, HIGH->MID threshold (level < value); must be < TH_HIGH_UP and > TH_MID_UP.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  single-cycle time-base pulse from the upstream counter.
- nourish  in  1  stimulus level, synchronous to clk; only rising edges count.
- stress  in  1  stimulus level, synchronous to clk; only rising edges count.
- level  out  WIDTH  current integrated level (registered).
- mood  out  2  registered mood: 0=LOW, 1=MID, 2=HIGH; 3 never driven.
- mood_changed  out  1  one-cycle pulse in the cycle `mood` takes a new value.
- decay_event  out  1  registered one-cycle pulse, asserted the cycle after a decay was applied.

Behaviour:
- Reset (async assert, sync-style release at next edge):
  - level = INIT_LEVEL, mood = LOW, mood_changed = 0, decay_event = 0.
  - Decay counter = 0.
  - Edge-detect history registers = 0. An input already high at reset release therefore counts as a rising edge on the first active cycle.
- Edge detection: inc_e = nourish & ~nourish_q, dec_e = stress & ~stress_q; history updates every cycle.
- Decay counter, range 0..DECAY_TICKS-1:
  - Advances only on `tick`.
  - decay_fire = tick & (cnt == DECAY_TICKS-1); on fire the counter wraps to 0.
  - With DECAY_TICKS = 1, every tick fires.
- Level update, every cycle:
  - sum = level + INC_STEP*inc_e - DEC_STEP*dec_e - DECAY_STEP*decay_fire.
  - Computed signed at WIDTH+3 bits, then clamped to [0, MAX_LEVEL].
  - Result is registered; latency is 1 cycle from the event cycle to the visible `level`.
  - Simultaneous events combine in the single sum. inc+dec with equal steps gives a net 0 change. No event is lost or deferred.
- decay_event is registered decay_fire, so it is high in the same cycle the decayed level becomes visible.
- Mood FSM:
  - Evaluated on the registered `level`, so `mood` lags `level` by 1 cycle.
  - At most one transition per cycle.
  - LOW -> MID if level >= TH_MID_UP.
  - MID -> LOW if level < TH_MID_DN; else MID -> HIGH if level >= TH_HIGH_UP.
  - HIGH -> MID if level < TH_HIGH_DN.
  - Otherwise hold.
  - A jump from LOW to HIGH takes two cycles, passing through MID with two mood_changed pulses.
- mood_changed = 1 exactly in the cycle the new `mood` value is first visible.
- Reset mid-operation: all state returns to reset values immediately; pending edges and decay progress are discarded.

Decomposition:
- Shared header `mood_defs.vh` holds:
  - MOOD_LOW = 2'd0, MOOD_MID = 2'd1, MOOD_HIGH = 2'd2;
  - MOOD_W = 2.
- The same mood encoding is consumed by the display/behaviour blocks.
- Sub-module `rising_edge_detect` (clk, rst, in, pulse), instantiated twice; reusable elsewhere in the design.
- The decay counter is inline: it is tick-gated and differs from the free-running pulse counter.

Test Plan:
- Reset with no stimulus:
  - During reset: level = 128, mood = LOW.
  - First cycle after release: mood = MID, mood_changed = 1 for exactly 1 cycle; level stays 128.
- Decay, tick every 10 cycles:
  - level stays 128 after ticks 1-3.
  - Cycle after the 4th tick: level = 127 with decay_event = 1; 127 after the 8th tick chain continues to 126.
  - decay_event is high only on those cycles.
- nourish held high for 20 cycles: exactly one +16, so level 128 -> 144. Drop and re-raise: 160.
- Saturation: 10 separate nourish edges from 128 -> level clamps at 255; mood goes MID -> HIGH once, in the cycle after level reaches >= 192.
- Hysteresis:
  - From level 192 in HIGH: one stress edge -> 176, mood stays HIGH; a second -> 160, mood = MID next cycle.
  - Drive down to 80: mood stays MID; one more stress edge -> 64, mood = LOW.
  - Underflow: stress edges at level 8 -> level 0, never wraps.
- Simultaneous events: nourish edge, stress edge and decay fire in the same cycle -> level 128 -> 127.
- Reset mid-operation: assert rst for 1 cycle mid-sequence with the decay counter at 2 -> level = 128, and the next decay occurs only after 4 further ticks.
